mdr_mem_port: RTL and testbench

Parametrised memory data register with a request/acknowledge memory port, sub-word load extraction with sign/zero extension, store lane replication with byte enables, and a misalignment check. Sits between the internal bus (BusMuxOut / BusMuxInMDR) and the memory subsystem. It replaces the single-cycle MDR, whose memory read was assumed to complete in one cycle, with a handshake that tolerates wait states.

---
 rtl/mdr_pkg.sv | 25 ++
 rtl/mdr_mem_port_if.sv | 17 +
 rtl/mdr_lane_align.sv | 70 +++++++
 rtl/mdr_mem_port.sv | 157 +++++++++++++++
 tb/tb_mdr_mem_port.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register port: access sizes, FSM states
// and the default ack timeout.
package mdr_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      WR_WAIT = 2'b10
   } state_t;

   localparam int TIMEOUT_CYC_DEF = 255;

   // A dword request on a 32-bit port degrades to a word access.
   function automatic size_t eff_size(input size_t sz, input int data_w);
      return (data_w == 32 && sz == SZ_DWORD) ? SZ_WORD : sz;
   endfunction

endpackage

// File: rtl/mdr_mem_port_if.sv
// Memory-side request/acknowledge bus of the MDR port.
interface mdr_mem_port_if #(parameter int DATA_W = 32);

   logic                  mem_rd;
   logic                  mem_wr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_ack;

   modport master (output mem_rd, mem_wr, mem_wdata, mem_be,
                   input  mem_rdata, mem_ack);

   modport slave  (input  mem_rd, mem_wr, mem_wdata, mem_be,
                   output mem_rdata, mem_ack);

endinterface

// File: rtl/mdr_lane_align.sv
// Combinational lane logic: load extraction/extension, store replication,
// byte enables and alignment check.
module mdr_lane_align
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  size_t                        ld_size,
   input  logic                         ld_sext,
   input  logic [$clog2(DATA_W/8)-1:0]  ld_off,
   input  logic [DATA_W-1:0]            rdata,
   output logic [DATA_W-1:0]            load_val,
   input  size_t                        st_size,
   input  logic [$clog2(DATA_W/8)-1:0]  st_off,
   input  logic [DATA_W-1:0]            mdr,
   output logic [DATA_W-1:0]            st_data,
   output logic [DATA_W/8-1:0]          st_be,
   output logic                         misalign
);

   localparam int BW = DATA_W / 8;

   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] msk;
   logic              sb;
   logic [BW-1:0]     be_base;

   // Lane at the latched offset is shifted down, masked, then the upper bits filled.
   always_comb begin
      sh  = rdata >> {ld_off, 3'b000};
      msk = '0;
      sb  = 1'b0;
      case (eff_size(ld_size, DATA_W))
         SZ_BYTE: begin msk[7:0]  = '1; sb = sh[7];  end
         SZ_HALF: begin msk[15:0] = '1; sb = sh[15]; end
         SZ_WORD: begin msk[31:0] = '1; sb = sh[31]; end
         default: begin msk       = '1; sb = 1'b0;   end
      endcase
      load_val = (sh & msk) | ((ld_sext && sb) ? ~msk : '0);
   end

   always_comb begin
      st_data  = mdr;
      be_base  = '1;
      misalign = 1'b0;
      case (eff_size(st_size, DATA_W))
         SZ_BYTE: begin
            st_data = {(DATA_W/8){mdr[7:0]}};
            be_base = BW'(1);
         end
         SZ_HALF: begin
            st_data  = {(DATA_W/16){mdr[15:0]}};
            be_base  = BW'(2'b11);
            misalign = st_off[0];
         end
         SZ_WORD: begin
            st_data  = {(DATA_W/32){mdr[31:0]}};
            be_base  = BW'(4'hF);
            misalign = |st_off[1:0];
         end
         default: begin
            st_data  = mdr;
            be_base  = '1;
            misalign = |st_off;
         end
      endcase
      st_be = be_base << st_off;
   end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with request/acknowledge memory port and sub-word lanes.
// Optional ack timeout enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_port
   import mdr_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         MDRin,
   input  logic                         read,
   input  logic                         write,
   input  logic [1:0]                   size,
   input  logic                         sext,
   input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
   input  logic [DATA_W-1:0]            BusMuxOut,
   output logic [DATA_W-1:0]            BusMuxInMDR,
   mdr_mem_port_if.master               mem,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int AW = $clog2(DATA_W/8);

   state_t            state;
   logic [DATA_W-1:0] mdr;
   size_t             ld_size;
   logic              ld_sext;
   logic [AW-1:0]     ld_off;

   logic [DATA_W-1:0]   load_val;
   logic [DATA_W-1:0]   st_data;
   logic [DATA_W/8-1:0] st_be;
   logic                misalign;

`ifdef MDR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wait_cnt;
   logic          expired;
   assign expired = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`endif

   assign BusMuxInMDR = mdr;

   mdr_lane_align #(.DATA_W(DATA_W)) u_align (
      .ld_size  (ld_size),
      .ld_sext  (ld_sext),
      .ld_off   (ld_off),
      .rdata    (mem.mem_rdata),
      .load_val (load_val),
      .st_size  (size_t'(size)),
      .st_off   (addr_lo),
      .mdr      (mdr),
      .st_data  (st_data),
      .st_be    (st_be),
      .misalign (misalign)
   );

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state         <= IDLE;
         mdr           <= '0;
         ld_size       <= SZ_BYTE;
         ld_sext       <= 1'b0;
         ld_off        <= '0;
         mem.mem_rd    <= 1'b0;
         mem.mem_wr    <= 1'b0;
         mem.mem_wdata <= '0;
         mem.mem_be    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
`ifdef MDR_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
`ifdef MDR_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               if (read) begin
                  if (misalign) begin
                     err <= 1'b1;
                  end else begin
                     state      <= RD_WAIT;
                     mem.mem_rd <= 1'b1;
                     busy       <= 1'b1;
                     ld_size    <= size_t'(size);
                     ld_sext    <= sext;
                     ld_off     <= addr_lo;
                  end
               end else if (write) begin
                  if (misalign) begin
                     err <= 1'b1;
                  end else begin
                     state         <= WR_WAIT;
                     mem.mem_wr    <= 1'b1;
                     busy          <= 1'b1;
                     mem.mem_wdata <= st_data;
                     mem.mem_be    <= st_be;
                  end
               end else if (MDRin) begin
                  mdr <= BusMuxOut;
               end
            end
            RD_WAIT: begin
               if (mem.mem_ack) begin
                  mdr        <= load_val;
                  mem.mem_rd <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= IDLE;
               end
`ifdef MDR_TIMEOUT_EN
               else if (expired) begin
                  mem.mem_rd <= 1'b0;
                  busy       <= 1'b0;
                  err        <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            WR_WAIT: begin
               if (mem.mem_ack) begin
                  mem.mem_wr    <= 1'b0;
                  mem.mem_wdata <= '0;
                  mem.mem_be    <= '0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  state         <= IDLE;
               end
`ifdef MDR_TIMEOUT_EN
               else if (expired) begin
                  mem.mem_wr    <= 1'b0;
                  mem.mem_wdata <= '0;
                  mem.mem_be    <= '0;
                  busy          <= 1'b0;
                  err           <= 1'b1;
                  state         <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port (DATA_W=32): vector table plus hand sequences.
module tb_mdr_mem_port;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic        MDRin = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sext = 1'b0;
   logic [1:0]  addr_lo = 2'b00;
   logic [31:0] BusMuxOut = '0;
   logic [31:0] BusMuxInMDR;
   logic        busy, done, err;

   int total = 0;
   int bad = 0;

   mdr_mem_port_if #(.DATA_W(32)) mif ();

   mdr_mem_port #(.DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk         (clk),
      .clear       (clear),
      .MDRin       (MDRin),
      .read        (read),
      .write       (write),
      .size        (size),
      .sext        (sext),
      .addr_lo     (addr_lo),
      .BusMuxOut   (BusMuxOut),
      .BusMuxInMDR (BusMuxInMDR),
      .mem         (mif),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        is_wr;
      logic [1:0]  sz;
      logic        sx;
      logic [1:0]  off;
      logic [31:0] data;    // read: mem_rdata; write: MDR preload
      logic [31:0] exp_a;   // read: MDR after ack; write: mem_wdata
      logic [3:0]  exp_be;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mdr_load(input logic [31:0] v);
      MDRin = 1'b1;
      BusMuxOut = v;
      tick();
      MDRin = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] pre;
      pre = v.is_wr ? v.data : 32'h5A5A_5A5A;
      mdr_load(pre);
      size = v.sz; sext = v.sx; addr_lo = v.off;
      if (v.is_wr) write = 1'b1; else read = 1'b1;
      tick();
      write = 1'b0; read = 1'b0;
      if (v.exp_err) begin
         chk({v.name, " err"}, 64'(err), 64'(1));
         chk({v.name, " no req"}, 64'({mif.mem_rd, mif.mem_wr, busy}), 64'(0));
         tick();
         chk({v.name, " err pulse"}, 64'(err), 64'(0));
         chk({v.name, " mdr kept"}, 64'(BusMuxInMDR), 64'(pre));
      end else if (v.is_wr) begin
         chk({v.name, " wr"}, 64'({mif.mem_wr, mif.mem_rd, busy}), 64'(3'b101));
         chk({v.name, " wdata"}, 64'(mif.mem_wdata), 64'(v.exp_a));
         chk({v.name, " be"}, 64'(mif.mem_be), 64'(v.exp_be));
         mif.mem_ack = 1'b1;
         addr_lo = ~v.off;
         tick();
         mif.mem_ack = 1'b0;
         chk({v.name, " after ack"}, 64'({mif.mem_wr, busy, done, mif.mem_be}), 64'({3'b001, 4'h0}));
         chk({v.name, " wdata clr"}, 64'(mif.mem_wdata), 64'(0));
         chk({v.name, " mdr kept"}, 64'(BusMuxInMDR), 64'(pre));
      end else begin
         chk({v.name, " rd"}, 64'({mif.mem_rd, mif.mem_wr, busy}), 64'(3'b101));
         mif.mem_rdata = v.data;
         mif.mem_ack = 1'b1;
         addr_lo = ~v.off;     // lane must come from the value latched at issue
         sext = ~v.sx;
         tick();
         mif.mem_ack = 1'b0;
         chk({v.name, " after ack"}, 64'({mif.mem_rd, busy, done}), 64'(3'b001));
         chk({v.name, " mdr"}, 64'(BusMuxInMDR), 64'(v.exp_a));
      end
      tick();
      chk({v.name, " done pulse"}, 64'({done, err}), 64'(0));
   endtask

   initial begin
      int busy_cnt, done_cnt, rd_cnt, err_cnt;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;

      vecs[0]  = '{"rd b sx o2",   1'b0, 2'b00, 1'b1, 2'd2, 32'h12F4_5678, 32'hFFFF_FFF4, 4'h0, 1'b0};
      vecs[1]  = '{"rd b zx o2",   1'b0, 2'b00, 1'b0, 2'd2, 32'h12F4_5678, 32'h0000_00F4, 4'h0, 1'b0};
      vecs[2]  = '{"rd b sx o0",   1'b0, 2'b00, 1'b1, 2'd0, 32'h12F4_5678, 32'h0000_0078, 4'h0, 1'b0};
      vecs[3]  = '{"rd b sx o3",   1'b0, 2'b00, 1'b1, 2'd3, 32'h9234_5678, 32'hFFFF_FF92, 4'h0, 1'b0};
      vecs[4]  = '{"rd h sx o2",   1'b0, 2'b01, 1'b1, 2'd2, 32'h8001_1234, 32'hFFFF_8001, 4'h0, 1'b0};
      vecs[5]  = '{"rd h zx o0",   1'b0, 2'b01, 1'b0, 2'd0, 32'h8001_F234, 32'h0000_F234, 4'h0, 1'b0};
      vecs[6]  = '{"rd w o0",      1'b0, 2'b10, 1'b1, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'h0, 1'b0};
      vecs[7]  = '{"rd dw as w",   1'b0, 2'b11, 1'b0, 2'd0, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'h0, 1'b0};
      vecs[8]  = '{"rd w mis o1",  1'b0, 2'b10, 1'b0, 2'd1, 32'h1111_1111, 32'h5A5A_5A5A, 4'h0, 1'b1};
      vecs[9]  = '{"rd h mis o3",  1'b0, 2'b01, 1'b0, 2'd3, 32'h1111_1111, 32'h5A5A_5A5A, 4'h0, 1'b1};
      vecs[10] = '{"wr b o3",      1'b1, 2'b00, 1'b0, 2'd3, 32'h1234_56A5, 32'hA5A5_A5A5, 4'b1000, 1'b0};
      vecs[11] = '{"wr h o2",      1'b1, 2'b01, 1'b0, 2'd2, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100, 1'b0};
      vecs[12] = '{"wr w o0",      1'b1, 2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0};
      vecs[13] = '{"wr w mis o2",  1'b1, 2'b10, 1'b0, 2'd2, 32'h0BAD_F00D, 32'h0, 4'h0, 1'b1};

      // reset state
      #12;
      chk("reset mdr", 64'(BusMuxInMDR), 64'(0));
      chk("reset strobes", 64'({mif.mem_rd, mif.mem_wr, busy, done, err}), 64'(0));
      chk("reset bus", 64'({mif.mem_wdata, mif.mem_be}), 64'(0));
      clear = 1'b1;
      tick();

      // MDRin load
      mdr_load(32'hDEAD_BEEF);
      chk("mdrin", 64'(BusMuxInMDR), 64'(32'hDEAD_BEEF));
      chk("mdrin no req", 64'({mif.mem_rd, mif.mem_wr, busy}), 64'(0));

      // ack while idle is ignored
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0101_0101;
      tick();
      mif.mem_ack = 1'b0;
      chk("idle ack", 64'({BusMuxInMDR, mif.mem_rd, done}), 64'({32'hDEAD_BEEF, 2'b00}));

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // read with three wait states
      mdr_load(32'h0);
      size = 2'b00; sext = 1'b1; addr_lo = 2'd2; mif.mem_rdata = 32'h12F4_5678;
      read = 1'b1;
      tick();
      read = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         mif.mem_ack = (i == 3);
         tick();
      end
      mif.mem_ack = 1'b0;
      chk("wait busy cycles", 64'(busy_cnt), 64'(4));
      chk("wait done pulses", 64'(done_cnt), 64'(1));
      chk("wait mdr", 64'(BusMuxInMDR), 64'(32'hFFFF_FFF4));

      // read and MDRin together: read wins
      mdr_load(32'h0);
      size = 2'b10; addr_lo = 2'd0; BusMuxOut = 32'h1111_1111;
      read = 1'b1; MDRin = 1'b1;
      tick();
      read = 1'b0; MDRin = 1'b0;
      chk("rd+mdrin req", 64'({mif.mem_rd, BusMuxInMDR}), 64'({1'b1, 32'h0}));
      mif.mem_rdata = 32'h7654_3210; mif.mem_ack = 1'b1;
      tick();
      mif.mem_ack = 1'b0;
      chk("rd+mdrin mdr", 64'(BusMuxInMDR), 64'(32'h7654_3210));

      // clear during RD_WAIT
      mdr_load(32'hA5A5_0F0F);
      size = 2'b10; addr_lo = 2'd0;
      read = 1'b1;
      tick();
      read = 1'b0;
      tick();
      #2 clear = 1'b0;
      #1;
      chk("abort async", 64'({mif.mem_rd, busy, BusMuxInMDR}), 64'(0));
      #1 clear = 1'b1;
      mif.mem_rdata = 32'hFFFF_FFFF; mif.mem_ack = 1'b1;
      tick();
      mif.mem_ack = 1'b0;
      chk("abort late ack", 64'({mif.mem_rd, busy, done, BusMuxInMDR}), 64'(0));

`ifdef MDR_TIMEOUT_EN
      // no ack: timeout after TIMEOUT_CYC=4 request cycles
      mdr_load(32'h1357_2468);
      size = 2'b10; addr_lo = 2'd0;
      read = 1'b1;
      tick();
      read = 1'b0;
      rd_cnt = 0; err_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (mif.mem_rd) rd_cnt++;
         if (err) err_cnt++;
         if (done) done_cnt++;
         tick();
      end
      chk("timeout rd cycles", 64'(rd_cnt), 64'(4));
      chk("timeout err", 64'(err_cnt), 64'(1));
      chk("timeout done", 64'(done_cnt), 64'(0));
      chk("timeout mdr", 64'({busy, BusMuxInMDR}), 64'({1'b0, 32'h1357_2468}));
`else
      rd_cnt = 0; err_cnt = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
